video_timing_gen: RTL and testbench
===================================

# video_timing_gen

Programmable, parametrised raster timing generator; successor to the fixed two-mode VGA timing block. Produces horizontal/vertical counters, syncs, blanking and frame/line strobes for the pixel pipeline. Timing, sync polarity and vertical line repeat are held in shadowed registers written by the host, so software can define any mode up to the counter width without RTL changes. Sits at the head of the video path and drives pixel fetch, palette and video DAC output.

## Interface

- `HW`, 10: horizontal counter width.
- `VW`, 10: vertical counter width.
- `DEF_H_ACT`/`DEF_H_SS`/`DEF_H_SE`/`DEF_H_LAST`, 640/656/752/799: reset horizontal timing.
- `DEF_V_ACT`/`DEF_V_SS`/`DEF_V_SE`/`DEF_V_LAST`, 480/490/492/524: reset vertical timing.

- `clk` in 1: pixel clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `cfg_wr` in 1: register write strobe, one write per cycle.
- `cfg_addr` in 4: register select.
- `cfg_wdata` in 12: write data, low bits used.
- `hpos` out HW: raw horizontal count.
- `hsync`, `vsync` out 1: syncs, polarity per flags.
- `hblank`, `vblank`, `blank` out 1: blanking; `blank` = `hblank` | `vblank`.
- `hlast` out 1: last pixel of the line.
- `vpos` out VW: logical line, i.e. raw line divided by the repeat factor.
- `vnext` out 1: `hlast` on the final repeat of a logical line.
- `vnewframe` out 1: registered pulse, first blanked line.
- `line_irq` out 1: registered pulse on a raster-compare match.

## Operation

- Register map, all writes staged into a pending set:
  - 0–3: `h_act`, `h_ss`, `h_se`, `h_last`.
  - 4–7: `v_act`, `v_ss`, `v_se`, `v_last`.
  - 8: flags, as `[3:2]` vrep (repeat = vrep+1), `[1]` hpol, `[0]` vpol (1 = active-high).
  - 9: `irq_line`, applied to the live set immediately.
  - Addresses 10–15 are ignored.
- Pending set copies to the live set only at frame end (`hlast` and `vcnt == v_last`). The copy happens in the same cycle the counters wrap to 0, so the new frame starts fully in the new mode. A write in that same cycle lands in pending, not live.
- Horizontal counter `hcnt`: 0..`h_last`, then wraps.
  - `hblank` = `hcnt >= h_act`.
  - Sync asserted for `h_ss <= hcnt < h_se`.
- Vertical counter `vcnt` increments on `hlast` and wraps after `v_last`.
  - `vblank` = `vcnt >= v_act`.
  - Sync asserted for `v_ss <= vcnt < v_se`.
- Repeat sub-counter `rcnt`: 0..vrep, advanced on `hlast`. `vpos` increments when `rcnt == vrep`. Both clear at frame wrap.
  - If `v_act` is not a multiple of the repeat, the last logical line is truncated.
- `hsync` output = asserted XNOR hpol; `vsync` likewise with vpol. Reset polarity is 0 (active-low).
- Degenerate programming (`h_se <= h_ss`, or `h_last < h_act`) yields no sync or no blank respectively. There is no lockup: counters always wrap at `h_last`/`v_last`.
- `vpos` wraps modulo 2^VW.

## Timing

- Syncs, blanks, `hpos`, `vpos`, `hlast` and `vnext` are combinational from the counters, with zero latency.
- `vnewframe`: one cycle after the `hlast` that moves `vcnt` to `v_act`. Width one cycle.
- `line_irq`: one cycle after the cycle where `vpos == irq_line`, `rcnt == 0` and `hcnt == h_act`. Fires once per frame per match.
- Reset, asynchronous assert, any time:
  - Counters and `rcnt` = 0.
  - Pending and live sets = parameter defaults; `irq_line` = 0.
  - `vnewframe` and `line_irq` = 0.
  - Resulting outputs: `hsync`/`vsync` deasserted (high), `blank` = 0.
- Reset is released synchronously to `clk` by the system reset synchroniser. The first count occurs on the first edge after deassertion.

## Structure

- Shared package `video_timing_pkg`:
  - register address constants.
  - flag bit positions.
  - default-mode constants, including a 704x480 set of 704/746/854/909 horizontal with 480/490/492/524 vertical.
- One sub-module, `video_timing_regs`: pending/live register bank and frame-end commit.
- The top level holds the counters, comparators and strobes.

## Test plan

- Reset defaults, run 2 frames:
  - `hlast` every 800 clocks.
  - `hsync` low for `hcnt` 656–751.
  - `vsync` low on lines 490–491.
  - `vnewframe` once per 420000 clocks.
- Write 704x480 set (h 704/746/854/909) mid-frame: current frame keeps 800-clock lines; the first line after wrap is 910 clocks.
- Flags vrep=1 (repeat 2), vpol=1: `vpos` 0..239 over 480 active lines, each held 2 lines; `vnext` every 2nd `hlast`; `vsync` high on lines 490–491.
- `irq_line` = 100, repeat 2: `line_irq` is a single pulse at raw line 200, `hcnt` 641.
- Write on the exact frame-end cycle: value takes effect one frame later.
- Assert `reset_n` low mid-line at `hcnt` = 300, line 50: all outputs return to reset values immediately; after release, counting restarts from 0 with default timing.

Source files
------------

// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - register map, flag layout and mode constants for video_timing_gen
package video_timing_pkg;

    localparam logic [3:0] ADDR_H_ACT    = 4'd0;
    localparam logic [3:0] ADDR_H_SS     = 4'd1;
    localparam logic [3:0] ADDR_H_SE     = 4'd2;
    localparam logic [3:0] ADDR_H_LAST   = 4'd3;
    localparam logic [3:0] ADDR_V_ACT    = 4'd4;
    localparam logic [3:0] ADDR_V_SS     = 4'd5;
    localparam logic [3:0] ADDR_V_SE     = 4'd6;
    localparam logic [3:0] ADDR_V_LAST   = 4'd7;
    localparam logic [3:0] ADDR_FLAGS    = 4'd8;
    localparam logic [3:0] ADDR_IRQ_LINE = 4'd9;

    localparam int FLAG_VPOL     = 0;
    localparam int FLAG_HPOL     = 1;
    localparam int FLAG_VREP_LSB = 2;
    localparam int FLAG_VREP_MSB = 3;
    localparam int FLAGS_W       = 4;

    localparam int VGA640_H_ACT  = 640;
    localparam int VGA640_H_SS   = 656;
    localparam int VGA640_H_SE   = 752;
    localparam int VGA640_H_LAST = 799;
    localparam int VGA640_V_ACT  = 480;
    localparam int VGA640_V_SS   = 490;
    localparam int VGA640_V_SE   = 492;
    localparam int VGA640_V_LAST = 524;

    localparam int SD704_H_ACT   = 704;
    localparam int SD704_H_SS    = 746;
    localparam int SD704_H_SE    = 854;
    localparam int SD704_H_LAST  = 909;
    localparam int SD704_V_ACT   = 480;
    localparam int SD704_V_SS    = 490;
    localparam int SD704_V_SE    = 492;
    localparam int SD704_V_LAST  = 524;

endpackage

// File: rtl/video_timing_regs.sv
// rtl/video_timing_regs.sv - pending/live timing register bank with frame-end commit
module video_timing_regs
    import video_timing_pkg::*;
#(
    parameter int HW         = 10,
    parameter int VW         = 10,
    parameter int DEF_H_ACT  = VGA640_H_ACT,
    parameter int DEF_H_SS   = VGA640_H_SS,
    parameter int DEF_H_SE   = VGA640_H_SE,
    parameter int DEF_H_LAST = VGA640_H_LAST,
    parameter int DEF_V_ACT  = VGA640_V_ACT,
    parameter int DEF_V_SS   = VGA640_V_SS,
    parameter int DEF_V_SE   = VGA640_V_SE,
    parameter int DEF_V_LAST = VGA640_V_LAST
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cfg_wr,
    input  logic [3:0]    cfg_addr,
    input  logic [11:0]   cfg_wdata,
    input  logic          commit,
    output logic [HW-1:0] h_act,
    output logic [HW-1:0] h_ss,
    output logic [HW-1:0] h_se,
    output logic [HW-1:0] h_last,
    output logic [VW-1:0] v_act,
    output logic [VW-1:0] v_ss,
    output logic [VW-1:0] v_se,
    output logic [VW-1:0] v_last,
    output logic [1:0]    vrep,
    output logic          hpol,
    output logic          vpol,
    output logic [VW-1:0] irq_line
);

    localparam logic [HW-1:0] H_DEF [4] = '{HW'(DEF_H_ACT), HW'(DEF_H_SS), HW'(DEF_H_SE), HW'(DEF_H_LAST)};
    localparam logic [VW-1:0] V_DEF [4] = '{VW'(DEF_V_ACT), VW'(DEF_V_SS), VW'(DEF_V_SE), VW'(DEF_V_LAST)};

    logic [HW-1:0]      h_pend_q [4];
    logic [HW-1:0]      h_live_q [4];
    logic [VW-1:0]      v_pend_q [4];
    logic [VW-1:0]      v_live_q [4];
    logic [FLAGS_W-1:0] flags_pend_q;
    logic [FLAGS_W-1:0] flags_live_q;
    logic [VW-1:0]      irq_line_q;
    logic               unused_wdata;

    assign unused_wdata = ^cfg_wdata;

    // Commit reads the pending set as it stood before this cycle's write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_pend_q     <= H_DEF;
            h_live_q     <= H_DEF;
            v_pend_q     <= V_DEF;
            v_live_q     <= V_DEF;
            flags_pend_q <= '0;
            flags_live_q <= '0;
            irq_line_q   <= '0;
        end else begin
            if (commit) begin
                h_live_q     <= h_pend_q;
                v_live_q     <= v_pend_q;
                flags_live_q <= flags_pend_q;
            end
            if (cfg_wr) begin
                case (cfg_addr)
                    ADDR_H_ACT, ADDR_H_SS, ADDR_H_SE, ADDR_H_LAST:
                        h_pend_q[cfg_addr[1:0]] <= cfg_wdata[HW-1:0];
                    ADDR_V_ACT, ADDR_V_SS, ADDR_V_SE, ADDR_V_LAST:
                        v_pend_q[cfg_addr[1:0]] <= cfg_wdata[VW-1:0];
                    ADDR_FLAGS:    flags_pend_q <= cfg_wdata[FLAGS_W-1:0];
                    ADDR_IRQ_LINE: irq_line_q   <= cfg_wdata[VW-1:0];
                    default: ;
                endcase
            end
        end
    end

    assign h_act    = h_live_q[0];
    assign h_ss     = h_live_q[1];
    assign h_se     = h_live_q[2];
    assign h_last   = h_live_q[3];
    assign v_act    = v_live_q[0];
    assign v_ss     = v_live_q[1];
    assign v_se     = v_live_q[2];
    assign v_last   = v_live_q[3];
    assign vrep     = flags_live_q[FLAG_VREP_MSB:FLAG_VREP_LSB];
    assign hpol     = flags_live_q[FLAG_HPOL];
    assign vpol     = flags_live_q[FLAG_VPOL];
    assign irq_line = irq_line_q;

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - programmable raster timing generator: counters, syncs, blanking, strobes
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int HW         = 10,
    parameter int VW         = 10,
    parameter int DEF_H_ACT  = VGA640_H_ACT,
    parameter int DEF_H_SS   = VGA640_H_SS,
    parameter int DEF_H_SE   = VGA640_H_SE,
    parameter int DEF_H_LAST = VGA640_H_LAST,
    parameter int DEF_V_ACT  = VGA640_V_ACT,
    parameter int DEF_V_SS   = VGA640_V_SS,
    parameter int DEF_V_SE   = VGA640_V_SE,
    parameter int DEF_V_LAST = VGA640_V_LAST
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cfg_wr,
    input  logic [3:0]    cfg_addr,
    input  logic [11:0]   cfg_wdata,
    output logic [HW-1:0] hpos,
    output logic          hsync,
    output logic          vsync,
    output logic          hblank,
    output logic          vblank,
    output logic          blank,
    output logic          hlast,
    output logic [VW-1:0] vpos,
    output logic          vnext,
    output logic          vnewframe,
    output logic          line_irq
);

    logic [HW-1:0] h_act, h_ss, h_se, h_last;
    logic [VW-1:0] v_act, v_ss, v_se, v_last, irq_line;
    logic [1:0]    vrep;
    logic          hpol, vpol;

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic [VW-1:0] vpos_q, vpos_d;
    logic [1:0]    rcnt_q, rcnt_d;
    logic          vnewframe_q, line_irq_q;
    logic          frame_end, rep_last, hs_act, vs_act, irq_hit;

    video_timing_regs #(
        .HW(HW), .VW(VW),
        .DEF_H_ACT(DEF_H_ACT), .DEF_H_SS(DEF_H_SS), .DEF_H_SE(DEF_H_SE), .DEF_H_LAST(DEF_H_LAST),
        .DEF_V_ACT(DEF_V_ACT), .DEF_V_SS(DEF_V_SS), .DEF_V_SE(DEF_V_SE), .DEF_V_LAST(DEF_V_LAST)
    ) u_regs (
        .clk(clk), .reset_n(reset_n), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .commit(frame_end),
        .h_act(h_act), .h_ss(h_ss), .h_se(h_se), .h_last(h_last),
        .v_act(v_act), .v_ss(v_ss), .v_se(v_se), .v_last(v_last),
        .vrep(vrep), .hpol(hpol), .vpol(vpol), .irq_line(irq_line)
    );

    assign hlast     = (hcnt_q == h_last);
    assign frame_end = hlast && (vcnt_q == v_last);
    assign rep_last  = (rcnt_q == vrep);

    always_comb begin
        hcnt_d = hcnt_q + 1'b1;
        vcnt_d = vcnt_q;
        rcnt_d = rcnt_q;
        vpos_d = vpos_q;
        if (hlast) begin
            hcnt_d = '0;
            if (frame_end) begin
                vcnt_d = '0;
                rcnt_d = '0;
                vpos_d = '0;
            end else begin
                vcnt_d = vcnt_q + 1'b1;
                if (rep_last) begin
                    rcnt_d = '0;
                    vpos_d = vpos_q + 1'b1;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
        end
    end

    assign irq_hit = (vpos_q == irq_line) && (rcnt_q == 2'd0) && (hcnt_q == h_act);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            rcnt_q      <= '0;
            vpos_q      <= '0;
            vnewframe_q <= 1'b0;
            line_irq_q  <= 1'b0;
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            rcnt_q      <= rcnt_d;
            vpos_q      <= vpos_d;
            vnewframe_q <= hlast && (vcnt_d == v_act);
            line_irq_q  <= irq_hit;
        end
    end

    // Degenerate windows (se <= ss, last < act) simply never match.
    assign hs_act    = (hcnt_q >= h_ss) && (hcnt_q < h_se);
    assign vs_act    = (vcnt_q >= v_ss) && (vcnt_q < v_se);
    assign hsync     = ~(hs_act ^ hpol);
    assign vsync     = ~(vs_act ^ vpol);
    assign hblank    = (hcnt_q >= h_act);
    assign vblank    = (vcnt_q >= v_act);
    assign blank     = hblank | vblank;
    assign hpos      = hcnt_q;
    assign vpos      = vpos_q;
    assign vnext     = hlast && rep_last;
    assign vnewframe = vnewframe_q;
    assign line_irq  = line_irq_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - self-checking bench for video_timing_gen against a frame-position model
module tb_video_timing_gen;

    localparam int HA = 40, HSS = 44, HSE = 50, HL = 59;
    localparam int VA = 20, VSS = 22, VSE = 24, VL = 29;
    localparam logic [28:0] RESET_VEC = {20'd0, 2'b11, 7'd0};

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_wr = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [11:0] cfg_wdata = '0;
    logic [9:0]  hpos, vpos;
    logic        hsync, vsync, hblank, vblank, blank, hlast, vnext, vnewframe, line_irq;
    logic [28:0] dut_vec;

    video_timing_gen #(
        .HW(10), .VW(10),
        .DEF_H_ACT(HA), .DEF_H_SS(HSS), .DEF_H_SE(HSE), .DEF_H_LAST(HL),
        .DEF_V_ACT(VA), .DEF_V_SS(VSS), .DEF_V_SE(VSE), .DEF_V_LAST(VL)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .hpos(hpos), .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank), .blank(blank),
        .hlast(hlast), .vpos(vpos), .vnext(vnext), .vnewframe(vnewframe), .line_irq(line_irq)
    );

    always #5 clk = ~clk;

    assign dut_vec = {hpos, vpos, hsync, vsync, hblank, vblank, blank, hlast, vnext, vnewframe, line_irq};

    // Model: position within frame t; live/pend indexed by register address 0..8.
    int   live [9];
    int   pend [9];
    int   irq_l, t;
    logic exp_nf, exp_irq;
    int   n_chk = 0, n_pass = 0;

    function automatic int rep(); return ((live[8] >> 2) & 3) + 1; endfunction
    function automatic int hc(); return t % (live[3] + 1); endfunction
    function automatic int ln(); return t / (live[3] + 1); endfunction
    function automatic int flen(); return (live[3] + 1) * (live[7] + 1); endfunction

    function automatic logic [28:0] m_vec();
        int   h, l, v, r;
        logic hp, vp, hs, vs, hb, vb, hl;
        h  = hc();
        l  = ln();
        v  = (l / rep()) % 1024;
        r  = l % rep();
        hp = ((live[8] >> 1) & 1) == 1;
        vp = (live[8] & 1) == 1;
        hs = (h >= live[1] && h < live[2]) ? hp : !hp;
        vs = (l >= live[5] && l < live[6]) ? vp : !vp;
        hb = (h >= live[0]);
        vb = (l >= live[4]);
        hl = (h == live[3]);
        return {10'(h), 10'(v), hs, vs, hb, vb, hb | vb, hl, hl && (r == rep() - 1), exp_nf, exp_irq};
    endfunction

    function automatic void set_defaults();
        live    = '{HA, HSS, HSE, HL, VA, VSS, VSE, VL, 0};
        pend    = live;
        irq_l   = 0;
        t       = 0;
        exp_nf  = 1'b0;
        exp_irq = 1'b0;
    endfunction

    task automatic tick(input bit wr, input int a, input int d);
        int nl;
        bit nf, irq;
        nl  = (hc() == live[3]) ? ((ln() == live[7]) ? 0 : ln() + 1) : -1;
        nf  = (nl == live[4]);
        irq = ((ln() / rep()) % 1024 == irq_l) && (ln() % rep() == 0) && (hc() == live[0]);
        cfg_wr    = wr;
        cfg_addr  = 4'(a);
        cfg_wdata = 12'(d);
        @(posedge clk);
        if (t == flen() - 1) begin
            live = pend;
            t    = 0;
        end else begin
            t++;
        end
        if (wr) begin
            if (a < 8) pend[a] = d % 1024;
            else if (a == 8) pend[8] = d & 15;
            else if (a == 9) irq_l = d % 1024;
        end
        exp_nf  = nf;
        exp_irq = irq;
        @(negedge clk);
        cfg_wr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 reset_n = 1'b0;
        cfg_wr = 1'b0;
        set_defaults();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1 reset_n = 1'b0;
        set_defaults();
        #1;
        n_chk++;
        if (dut_vec !== RESET_VEC) $display("FAIL reset_assert got=%h exp=%h", dut_vec, RESET_VEC);
        else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (dut_vec !== RESET_VEC) $display("FAIL reset_hold got=%h exp=%h", dut_vec, RESET_VEC);
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        tick(0, 0, 0);
        n_chk++;
        if (hpos !== 10'd1) $display("FAIL reset_first_count hpos=%0d exp=1", hpos);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_default_frames();
        int hl_cnt = 0, nf_cnt = 0, hs_bad = 0, vs_low = 0, per_bad = 0, last_hl = -1;
        for (int i = 0; i < 2 * 60 * 30; i++) begin
            n_chk++;
            if (dut_vec !== m_vec()) $display("FAIL default_vec t=%0d got=%h exp=%h", t, dut_vec, m_vec());
            else n_pass++;
            if (hlast) begin
                if (last_hl >= 0 && i - last_hl != 60) per_bad++;
                last_hl = i;
                hl_cnt++;
            end
            if (vnewframe) nf_cnt++;
            if (!vsync) vs_low++;
            if ((hsync == 1'b0) != (hpos >= 10'd44 && hpos < 10'd50)) hs_bad++;
            tick(0, 0, 0);
        end
        n_chk++; if (hl_cnt !== 60) $display("FAIL default_hlast_count got=%0d exp=60", hl_cnt); else n_pass++;
        n_chk++; if (per_bad !== 0) $display("FAIL default_hlast_period bad=%0d exp=0", per_bad); else n_pass++;
        n_chk++; if (nf_cnt !== 2) $display("FAIL default_vnewframe got=%0d exp=2", nf_cnt); else n_pass++;
        n_chk++; if (hs_bad !== 0) $display("FAIL default_hsync_window bad=%0d exp=0", hs_bad); else n_pass++;
        n_chk++; if (vs_low !== 240) $display("FAIL default_vsync_low got=%0d exp=240", vs_low); else n_pass++;
    endtask

    task automatic test_mode_switch();
        int rem, per_bad = 0, last_hl = -1, first_hl = -1, hs_low = 0;
        for (int i = 0; i < 900; i++) tick(0, 0, 0);
        tick(1, 0, 704);
        tick(1, 1, 746);
        tick(1, 2, 854);
        tick(1, 3, 909);
        rem = flen() - t;
        for (int i = 0; i < rem; i++) begin
            n_chk++;
            if (dut_vec !== m_vec()) $display("FAIL switch_old_vec t=%0d got=%h exp=%h", t, dut_vec, m_vec());
            else n_pass++;
            if (hlast) begin
                if (last_hl >= 0 && i - last_hl != 60) per_bad++;
                last_hl = i;
            end
            tick(0, 0, 0);
        end
        for (int i = 0; i < 910; i++) begin
            n_chk++;
            if (dut_vec !== m_vec()) $display("FAIL switch_new_vec t=%0d got=%h exp=%h", t, dut_vec, m_vec());
            else n_pass++;
            if (hlast && first_hl < 0) first_hl = i;
            if (!hsync) hs_low++;
            tick(0, 0, 0);
        end
        n_chk++; if (per_bad !== 0) $display("FAIL switch_old_period bad=%0d exp=0", per_bad); else n_pass++;
        n_chk++; if (first_hl !== 909) $display("FAIL switch_new_line got=%0d exp=909", first_hl); else n_pass++;
        n_chk++; if (hs_low !== 108) $display("FAIL switch_new_hsync got=%0d exp=108", hs_low); else n_pass++;
    endtask

    task automatic test_vrep();
        int rem, max_vpos = 0, vn_cnt = 0, vs_high = 0;
        do_reset();
        tick(1, 8, 5);
        rem = flen() - t;
        for (int i = 0; i < rem; i++) tick(0, 0, 0);
        for (int i = 0; i < 1800; i++) begin
            n_chk++;
            if (dut_vec !== m_vec()) $display("FAIL vrep_vec t=%0d got=%h exp=%h", t, dut_vec, m_vec());
            else n_pass++;
            if (!vblank && int'(vpos) > max_vpos) max_vpos = int'(vpos);
            if (vnext) vn_cnt++;
            if (vsync) vs_high++;
            tick(0, 0, 0);
        end
        n_chk++; if (max_vpos !== 9) $display("FAIL vrep_max_vpos got=%0d exp=9", max_vpos); else n_pass++;
        n_chk++; if (vn_cnt !== 15) $display("FAIL vrep_vnext got=%0d exp=15", vn_cnt); else n_pass++;
        n_chk++; if (vs_high !== 120) $display("FAIL vrep_vsync_high got=%0d exp=120", vs_high); else n_pass++;
    endtask

    task automatic test_irq();
        int cnt = 0, pos = -1;
        tick(1, 9, 5);
        for (int c = 1; c < 1800; c++) begin
            n_chk++;
            if (dut_vec !== m_vec()) $display("FAIL irq_vec t=%0d got=%h exp=%h", t, dut_vec, m_vec());
            else n_pass++;
            if (line_irq) begin
                cnt++;
                pos = c;
            end
            tick(0, 0, 0);
        end
        n_chk++; if (cnt !== 1) $display("FAIL irq_count got=%0d exp=1", cnt); else n_pass++;
        n_chk++; if (pos !== 641) $display("FAIL irq_position got=%0d exp=641", pos); else n_pass++;
    endtask

    task automatic test_frame_end_write();
        int rem, hl1 = -1, hl2 = -1;
        do_reset();
        rem = flen() - 1;
        for (int i = 0; i < rem; i++) tick(0, 0, 0);
        tick(1, 3, 49);
        for (int i = 0; i < 1800; i++) begin
            n_chk++;
            if (dut_vec !== m_vec()) $display("FAIL fe_write_old t=%0d got=%h exp=%h", t, dut_vec, m_vec());
            else n_pass++;
            if (hlast && hl1 < 0) hl1 = i;
            tick(0, 0, 0);
        end
        for (int i = 0; i < 1500; i++) begin
            n_chk++;
            if (dut_vec !== m_vec()) $display("FAIL fe_write_new t=%0d got=%h exp=%h", t, dut_vec, m_vec());
            else n_pass++;
            if (hlast && hl2 < 0) hl2 = i;
            tick(0, 0, 0);
        end
        n_chk++; if (hl1 !== 59) $display("FAIL fe_write_delay got=%0d exp=59", hl1); else n_pass++;
        n_chk++; if (hl2 !== 49) $display("FAIL fe_write_applied got=%0d exp=49", hl2); else n_pass++;
    endtask

    task automatic test_reset_midline();
        do_reset();
        for (int i = 0; i < 5 * 60 + 30; i++) tick(0, 0, 0);
        n_chk++;
        if (hpos !== 10'd30) $display("FAIL midline_pre hpos=%0d exp=30", hpos);
        else n_pass++;
        #2 reset_n = 1'b0;
        set_defaults();
        #1;
        n_chk++;
        if (dut_vec !== RESET_VEC) $display("FAIL midline_async got=%h exp=%h", dut_vec, RESET_VEC);
        else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            n_chk++;
            if (dut_vec !== m_vec()) $display("FAIL midline_restart t=%0d got=%h exp=%h", t, dut_vec, m_vec());
            else n_pass++;
            tick(0, 0, 0);
        end
    endtask

    task automatic test_random();
        int rem;
        do_reset();
        tick(1, 0, $urandom_range(10, 30));
        tick(1, 1, $urandom_range(0, 40));
        tick(1, 2, $urandom_range(0, 40));
        tick(1, 3, $urandom_range(8, 40));
        tick(1, 4, $urandom_range(3, 12));
        tick(1, 5, $urandom_range(0, 15));
        tick(1, 6, $urandom_range(0, 15));
        tick(1, 7, $urandom_range(4, 15));
        tick(1, 8, $urandom_range(0, 15));
        tick(1, 9, $urandom_range(0, 6));
        rem = flen() - t;
        for (int i = 0; i < rem; i++) tick(0, 0, 0);
        for (int i = 0; i < 5000; i++) begin
            n_chk++;
            if (dut_vec !== m_vec()) $display("FAIL random_vec t=%0d got=%h exp=%h", t, dut_vec, m_vec());
            else n_pass++;
            if ($urandom_range(0, 39) == 0) tick(1, $urandom_range(0, 15), $urandom_range(0, 40));
            else tick(0, 0, 0);
        end
    endtask

    initial begin
        set_defaults();
        test_reset();
        test_default_frames();
        test_mode_switch();
        test_vrep();
        test_irq();
        test_frame_end_write();
        test_reset_midline();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
